// File: rtl/btn_dir_if.sv
// Button/direction bus between btn_dir_ctrl and its environment.
// The DUT side uses the slave modport. state_dbg exposes the FSM state for observation.
interface btn_dir_if;
    // There is no valid/ready pair on this bus.
    // Each pulse is a one-cycle strobe that is always accepted.
    // dir is valid on every cycle and changes only on the edge that raises a strobe.
    logic       btn_n;
    logic       btn_level;
    logic       dir;
    logic       press_pulse;
    logic       long_pulse;
    logic [1:0] state_dbg;

    modport master (
        output btn_n,
        input  btn_level, dir, press_pulse, long_pulse, state_dbg
    );

    modport slave (
        input  btn_n,
        output btn_level, dir, press_pulse, long_pulse, state_dbg
    );
endinterface

// File: rtl/btn_dir_ctrl.sv
// Push-button front end: synchronizer, debouncer and a press FSM that drives the LED direction bit.
// Define LONG_PRESS_EN to compile in long-press detection (hold counter, HELD state, long_pulse).
module btn_dir_ctrl #(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   LONG_CYCLES     = 100000000,
    parameter logic DIR_INIT        = 1'b1
) (
    input logic     clk,
    input logic     rst,
    btn_dir_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } state_t;

    logic            s1_q, s1_d;
    logic            sync_q, sync_d;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic            press_q, press_d;
    logic            long_q, long_d;

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    always_comb begin
        s1_d     = bus.btn_n;
        sync_d   = s1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        // Count only while the synchronized input disagrees with the accepted level.
        // The counter restarts after any bounce, and it never passes DB_LAST.
        if (sync_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        state_d = state_q;
        dir_d   = dir_q;
        press_d = 1'b0;
        long_d  = 1'b0;
`ifdef LONG_PRESS_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            RELEASED: begin
                if (!level_q) begin
                    state_d = PRESSED;
`ifdef LONG_PRESS_EN
                    hold_d  = '0;
`else
                    dir_d   = ~dir_q;
                    press_d = 1'b1;
`endif
                end
            end
            PRESSED: begin
                // A release is checked before hold expiry.
                // A release on the expiry cycle therefore counts as a short press.
                if (level_q) begin
                    state_d = RELEASED;
`ifdef LONG_PRESS_EN
                    dir_d   = ~dir_q;
                    press_d = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = HELD;
                    dir_d   = DIR_INIT;
                    long_d  = 1'b1;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
`endif
                end
            end
            HELD: begin
                if (level_q) state_d = RELEASED;
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q     <= 1'b1;
            sync_q   <= 1'b1;
            level_q  <= 1'b1;
            db_cnt_q <= '0;
            state_q  <= RELEASED;
            dir_q    <= DIR_INIT;
            press_q  <= 1'b0;
            long_q   <= 1'b0;
`ifdef LONG_PRESS_EN
            hold_q   <= '0;
`endif
        end else begin
            s1_q     <= s1_d;
            sync_q   <= sync_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            dir_q    <= dir_d;
            press_q  <= press_d;
            long_q   <= long_d;
`ifdef LONG_PRESS_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.dir         = dir_q;
    assign bus.press_pulse = press_q;
`ifdef LONG_PRESS_EN
    assign bus.long_pulse  = long_q;
`else
    assign bus.long_pulse  = 1'b0;
`endif
    assign bus.state_dbg   = state_q;
endmodule
